ctrl_pipe_hazard: RTL and testbench

- Next-generation pipelined control unit for the 5-stage RV32I core.
- Integrated blocks:
  - main/ALU decode
  - parametrised D->E->M->W control pipeline with stall/flush
  - full six-way branch resolution, including unsigned compares
  - load-use hazard detection
  - saturating branch performance counters
- Sits beside the datapath. Consumes decode-stage instruction fields and execute-stage flags; drives muxes, write enables, stall and flush lines.

---
 rtl/ctrl_pipe_hazard.sv | 103 ++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: RV32I control unit with D/E/M/W control pipeline, branch resolution, load-use hazard and branch counters
module ctrl_pipe_hazard #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           RdE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic                 ALUSrcAE,
  output logic                 ALUSrcBE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ResultSrcE0,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic                 PCSrcE,
  output logic                 PCJalrE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 IllegalW,
  output logic [CNT_W-1:0]     BrTotal,
  output logic [CNT_W-1:0]     BrTaken
);
  logic reg_write_d, mem_write_d, branch_d, jump_d, jalr_d, src_a_d, src_b_d, illegal_d;
  logic [1:0] result_src_d;
  logic [3:0] alu_ctl_d, alu_ri;
  logic reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, illegal_e;
  logic [1:0] result_src_e;
  logic [2:0] funct3_e;
  logic [1:0] result_src_m;
  logic illegal_m, cond, lw_stall, flush_e;
  always_comb
    alu_ri = funct3 == 3'b000 ? {3'b000, funct7b5 & op[5]} :
             funct3 == 3'b001 ? 4'b0111 :
             funct3 == 3'b010 ? 4'b0101 :
             funct3 == 3'b011 ? 4'b0110 :
             funct3 == 3'b100 ? 4'b0100 :
             funct3 == 3'b101 ? (funct7b5 ? 4'b1001 : 4'b1000) :
             funct3 == 3'b110 ? 4'b0011 : 4'b0010;
  always_comb begin
    reg_write_d = 1'b0;
    mem_write_d = 1'b0;
    branch_d = 1'b0;
    jump_d = 1'b0;
    jalr_d = 1'b0;
    src_a_d = 1'b0;
    src_b_d = 1'b0;
    result_src_d = 2'b00;
    ImmSrcD = 3'b000;
    alu_ctl_d = 4'b0000;
    illegal_d = 1'b0;
    case (op)
      7'b0110011: begin reg_write_d = 1'b1; alu_ctl_d = alu_ri; end
      7'b0010011: begin reg_write_d = 1'b1; src_b_d = 1'b1; alu_ctl_d = alu_ri; end
      7'b0000011: begin reg_write_d = 1'b1; src_b_d = 1'b1; result_src_d = 2'b01; end
      7'b0100011: begin mem_write_d = 1'b1; src_b_d = 1'b1; ImmSrcD = 3'b001; end
      7'b1100011: begin branch_d = 1'b1; ImmSrcD = 3'b010; alu_ctl_d = 4'b0001; end
      7'b1101111: begin reg_write_d = 1'b1; jump_d = 1'b1; result_src_d = 2'b10; ImmSrcD = 3'b011; end
      7'b1100111: begin reg_write_d = 1'b1; jump_d = 1'b1; jalr_d = 1'b1; src_b_d = 1'b1; result_src_d = 2'b10; end
      7'b0110111: begin reg_write_d = 1'b1; src_b_d = 1'b1; result_src_d = 2'b11; ImmSrcD = 3'b100; end
      7'b0010111: begin reg_write_d = 1'b1; src_a_d = 1'b1; src_b_d = 1'b1; ImmSrcD = 3'b100; end
      default: illegal_d = 1'b1;
    endcase
  end
  always_comb
    cond = funct3_e[2:1] == 2'b00 ? ZeroE ^ funct3_e[0] :
           funct3_e[2:1] == 2'b10 ? LtE ^ funct3_e[0] :
           funct3_e[2:1] == 2'b11 ? LtuE ^ funct3_e[0] : 1'b0;
  assign PCSrcE = (branch_e & cond) | jump_e;
  assign PCJalrE = jump_e & jalr_e;
  assign FlushD = PCSrcE;
  assign lw_stall = (result_src_e == 2'b01) & reg_write_e & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign flush_e = lw_stall | PCSrcE;
  assign ResultSrcE0 = result_src_e[0];
  always_ff @(posedge clk) begin
    {reg_write_e, mem_write_e, jump_e, branch_e, jalr_e, ALUSrcAE, ALUSrcBE, result_src_e, ALUControlE, funct3_e, illegal_e} <=
      (reset | flush_e) ? '0 :
      {reg_write_d, mem_write_d, jump_d, branch_d, jalr_d, src_a_d, src_b_d, result_src_d, ALUCTRL_W'(alu_ctl_d), funct3, illegal_d};
    {RegWriteM, MemWriteM, result_src_m, illegal_m} <= reset ? '0 : {reg_write_e, mem_write_e, result_src_e, illegal_e};
    {RegWriteW, ResultSrcW, IllegalW} <= reset ? '0 : {RegWriteM, result_src_m, illegal_m};
  end
  always_ff @(posedge clk)
    if (reset) begin
      BrTotal <= '0;
      BrTaken <= '0;
    end else begin
      if (branch_e && BrTotal != '1) BrTotal <= BrTotal + CNT_W'(1);
      if (branch_e && cond && BrTaken != '1) BrTaken <= BrTaken + CNT_W'(1);
    end
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: directed table and sequence checks for ctrl_pipe_hazard
module tb_ctrl_pipe_hazard;
  localparam int CNT_W = 8;
  logic clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic ZeroE, LtE, LtuE;
  logic [2:0] ImmSrcD;
  logic ALUSrcAE, ALUSrcBE, ResultSrcE0, MemWriteM, RegWriteM, RegWriteW;
  logic [3:0] ALUControlE;
  logic [1:0] ResultSrcW;
  logic PCSrcE, PCJalrE, StallF, StallD, FlushD, IllegalW;
  logic [CNT_W-1:0] BrTotal, BrTaken;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    logic [2:0] imm;
    logic [3:0] alu;
    logic a;
    logic b;
    logic rs0;
    logic mw_m;
    logic rw_m;
    logic rw_w;
    logic [1:0] rs_w;
    logic ill_w;
  } vec_t;
  vec_t vecs[15];
  vec_t v;
  ctrl_pipe_hazard #(.ALUCTRL_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(ImmSrcD), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ALUControlE(ALUControlE),
    .ResultSrcE0(ResultSrcE0), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .PCSrcE(PCSrcE), .PCJalrE(PCJalrE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .IllegalW(IllegalW), .BrTotal(BrTotal), .BrTaken(BrTaken)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic setd(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask
  task automatic filler;
    setd(7'b0010011, 3'b000, 1'b0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 3'b000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[2]  = '{7'b0110011, 3'b101, 1'b1, 3'b000, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[3]  = '{7'b0110011, 3'b101, 1'b0, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[4]  = '{7'b0110011, 3'b011, 1'b0, 3'b000, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[5]  = '{7'b0010011, 3'b000, 1'b1, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[6]  = '{7'b0010011, 3'b101, 1'b1, 3'b000, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[7]  = '{7'b0010011, 3'b100, 1'b0, 3'b000, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[8]  = '{7'b0000011, 3'b010, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[9]  = '{7'b0100011, 3'b010, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[10] = '{7'b1100011, 3'b000, 1'b0, 3'b010, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{7'b0110111, 3'b000, 1'b0, 3'b100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0};
    vecs[12] = '{7'b0010111, 3'b000, 1'b0, 3'b100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[13] = '{7'b1101111, 3'b000, 1'b0, 3'b011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
    vecs[14] = '{7'b1111111, 3'b000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    reset = 1'b1;
    setd(7'b1111111, 3'b000, 1'b0);
    Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_alu", 32'(ALUControlE), 32'h0);
    chk("rst_srcb", 32'(ALUSrcBE), 32'h0);
    chk("rst_rwm", 32'(RegWriteM), 32'h0);
    chk("rst_rww", 32'(RegWriteW), 32'h0);
    chk("rst_illw", 32'(IllegalW), 32'h0);
    chk("rst_total", 32'(BrTotal), 32'h0);
    chk("rst_taken", 32'(BrTaken), 32'h0);
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      setd(v.op, v.f3, v.f7);
      #1;
      chk($sformatf("v%0d_imm", i), 32'(ImmSrcD), 32'(v.imm));
      tick();
      chk($sformatf("v%0d_alu", i), 32'(ALUControlE), 32'(v.alu));
      chk($sformatf("v%0d_srca", i), 32'(ALUSrcAE), 32'(v.a));
      chk($sformatf("v%0d_srcb", i), 32'(ALUSrcBE), 32'(v.b));
      chk($sformatf("v%0d_rse0", i), 32'(ResultSrcE0), 32'(v.rs0));
      filler();
      tick();
      chk($sformatf("v%0d_mwm", i), 32'(MemWriteM), 32'(v.mw_m));
      chk($sformatf("v%0d_rwm", i), 32'(RegWriteM), 32'(v.rw_m));
      tick();
      chk($sformatf("v%0d_rww", i), 32'(RegWriteW), 32'(v.rw_w));
      chk($sformatf("v%0d_rsw", i), 32'(ResultSrcW), 32'(v.rs_w));
      chk($sformatf("v%0d_illw", i), 32'(IllegalW), 32'(v.ill_w));
    end
    do_reset();
    setd(7'b0000011, 3'b010, 1'b0);
    Rs1D = 5'd1; Rs2D = 5'd2;
    tick();
    setd(7'b0110011, 3'b000, 1'b1);
    Rs1D = 5'd5; Rs2D = 5'd6; RdE = 5'd5;
    #1;
    chk("lu_stallf", 32'(StallF), 32'h1);
    chk("lu_stalld", 32'(StallD), 32'h1);
    chk("lu_flushd", 32'(FlushD), 32'h0);
    chk("lu_rse0", 32'(ResultSrcE0), 32'h1);
    tick();
    chk("lu_bubble_alu", 32'(ALUControlE), 32'h0);
    chk("lu_bubble_stall", 32'(StallF), 32'h0);
    chk("lu_lw_rwm", 32'(RegWriteM), 32'h1);
    tick();
    chk("lu_sub_alu", 32'(ALUControlE), 32'h1);
    chk("lu_bubble_rwm", 32'(RegWriteM), 32'h0);
    chk("lu_lw_rww", 32'(RegWriteW), 32'h1);
    chk("lu_lw_rsw", 32'(ResultSrcW), 32'h1);
    tick();
    chk("lu_sub_rwm", 32'(RegWriteM), 32'h1);
    chk("lu_bubble_rww", 32'(RegWriteW), 32'h0);
    do_reset();
    setd(7'b0000011, 3'b010, 1'b0);
    RdE = 5'd0;
    tick();
    setd(7'b0110011, 3'b000, 1'b1);
    RdE = 5'd5; Rs1D = 5'd7; Rs2D = 5'd5;
    #1;
    chk("lu_rs2_stalld", 32'(StallD), 32'h1);
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #1;
    chk("lu_x0_stallf", 32'(StallF), 32'h0);
    tick();
    chk("lu_x0_alu", 32'(ALUControlE), 32'h1);
    do_reset();
    setd(7'b1100011, 3'b110, 1'b0);
    tick();
    LtuE = 1'b1; LtE = 1'b0;
    filler();
    #1;
    chk("bltu_pcsrc", 32'(PCSrcE), 32'h1);
    chk("bltu_flushd", 32'(FlushD), 32'h1);
    chk("bltu_jalr", 32'(PCJalrE), 32'h0);
    tick();
    chk("bltu_total", 32'(BrTotal), 32'h1);
    chk("bltu_taken", 32'(BrTaken), 32'h1);
    setd(7'b1100011, 3'b101, 1'b0);
    LtuE = 1'b0; LtE = 1'b1;
    tick();
    chk("flushed_rwm", 32'(RegWriteM), 32'h0);
    chk("bge_pcsrc", 32'(PCSrcE), 32'h0);
    chk("bge_flushd", 32'(FlushD), 32'h0);
    filler();
    tick();
    chk("bge_total", 32'(BrTotal), 32'h2);
    chk("bge_taken", 32'(BrTaken), 32'h1);
    setd(7'b1100011, 3'b010, 1'b0);
    ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1;
    tick();
    chk("f3_010_pcsrc", 32'(PCSrcE), 32'h0);
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    do_reset();
    setd(7'b1100111, 3'b000, 1'b0);
    tick();
    filler();
    #1;
    chk("jalr_pcsrc", 32'(PCSrcE), 32'h1);
    chk("jalr_pcjalr", 32'(PCJalrE), 32'h1);
    chk("jalr_flushd", 32'(FlushD), 32'h1);
    chk("jalr_srcb", 32'(ALUSrcBE), 32'h1);
    tick();
    tick();
    chk("jalr_rsw", 32'(ResultSrcW), 32'h2);
    chk("jalr_rww", 32'(RegWriteW), 32'h1);
    setd(7'b1101111, 3'b000, 1'b0);
    tick();
    chk("jal_pcsrc", 32'(PCSrcE), 32'h1);
    chk("jal_pcjalr", 32'(PCJalrE), 32'h0);
    do_reset();
    setd(7'b1100011, 3'b000, 1'b0);
    ZeroE = 1'b1;
    repeat (510) tick();
    chk("sat_total_max", 32'(BrTotal), 32'hFF);
    chk("sat_taken_max", 32'(BrTaken), 32'hFF);
    repeat (2) tick();
    chk("sat_total_hold", 32'(BrTotal), 32'hFF);
    chk("sat_taken_hold", 32'(BrTaken), 32'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("sat_rst_total", 32'(BrTotal), 32'h0);
    chk("sat_rst_taken", 32'(BrTaken), 32'h0);
    ZeroE = 1'b0;
    setd(7'b1111111, 3'b000, 1'b0);
    #1;
    chk("ill_imm", 32'(ImmSrcD), 32'h0);
    tick();
    filler();
    tick();
    chk("ill_mwm", 32'(MemWriteM), 32'h0);
    chk("ill_rwm", 32'(RegWriteM), 32'h0);
    tick();
    chk("ill_illw", 32'(IllegalW), 32'h1);
    chk("ill_rww", 32'(RegWriteW), 32'h0);
    tick();
    chk("ill_not_sticky", 32'(IllegalW), 32'h0);
    chk("ill_next_rww", 32'(RegWriteW), 32'h1);
    setd(7'b0000011, 3'b010, 1'b0);
    tick();
    setd(7'b0100011, 3'b010, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_srcb", 32'(ALUSrcBE), 32'h0);
    chk("mid_rse0", 32'(ResultSrcE0), 32'h0);
    chk("mid_mwm", 32'(MemWriteM), 32'h0);
    chk("mid_rwm", 32'(RegWriteM), 32'h0);
    chk("mid_rww", 32'(RegWriteW), 32'h0);
    chk("mid_rsw", 32'(ResultSrcW), 32'h0);
    chk("mid_illw", 32'(IllegalW), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
